// File: rtl/gpregs_pkg.sv
// Shared definitions for the general-purpose register file and its scoreboard.
package gpregs_pkg;

  localparam int REG_ZERO       = 0;
  localparam int RV32E_NUM_REGS = 16;

  // Register address width for a given register count (at least one bit).
  function automatic int addr_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  // Bit offset of one port's field inside a flattened multi-port bus.
  function automatic int port_lsb(input int port, input int field_w);
    return port * field_w;
  endfunction

  // True when an address names a physically present register.
  function automatic logic reg_in_range(input int unsigned idx, input int unsigned num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/gpregs_scoreboard.sv
// Per-register busy bits: issue reserves a destination, writeback releases it.
// Issue has priority over a same-cycle clear so a fresh reservation is never lost.
module gpregs_scoreboard
  import gpregs_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_READ*ADDR_W-1:0] read_addr,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_rd,
  input  logic                       wb_enable,
  input  logic [ADDR_W-1:0]          wb_rd,
  output logic                       issue_ready,
  output logic [NUM_READ-1:0]        read_busy,
  output logic [NUM_REGS-1:0]        busy_vec
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [ADDR_W-1:0]   rd_addr [NUM_READ];
  logic                wb_live;

  // Register 0 (when hardwired) and out-of-range addresses never hold a reservation.
  function automatic logic trackable(input logic [ADDR_W-1:0] a);
    return reg_in_range(32'(a), NUM_REGS) && !((ZERO_REG != 0) && (a == ADDR_W'(REG_ZERO)));
  endfunction

  // A writeback presented while reset is held is discarded, including its forwarding effect.
  assign wb_live  = wb_enable && !rst;
  assign busy_vec = busy_q;

  // Split the flattened read address bus into per-port addresses.
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rd_addr[i] = read_addr[port_lsb(i, ADDR_W) +: ADDR_W];
    end
  end

  // Readiness looks only at registered busy state, keeping writeback off this path.
  always_comb begin
    issue_ready = 1'b1;
    if (trackable(issue_rd)) begin
      issue_ready = !busy_q[issue_rd];
    end
  end

  // Next busy state: clear on writeback first, then set on accepted issue.
  always_comb begin
    busy_d = busy_q;
    if (wb_enable && trackable(wb_rd)) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (issue_valid && issue_ready && trackable(issue_rd)) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  // Per-port busy view, with a same-cycle writeback treated as already retired when forwarding.
  always_comb begin
    read_busy = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      if (trackable(rd_addr[i])) begin
        read_busy[i] = busy_q[rd_addr[i]];
        if ((BYPASS != 0) && wb_live && (wb_rd == rd_addr[i])) begin
          read_busy[i] = 1'b0;
        end
      end
    end
  end

  // Busy bit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/gpregs_sb.sv
// General-purpose register file: N combinational read ports, one writeback port,
// optional writeback-to-read forwarding, and an integrated busy scoreboard.
module gpregs_sb
  import gpregs_pkg::*;
#(
  parameter int REG_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 32,
  parameter int NUM_READ       = 2,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1,
  parameter int ADDR_W         = addr_w(NUM_REGS)
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic [NUM_READ*ADDR_W-1:0]         read_addr,
  output logic [NUM_READ*REG_DATA_WIDTH-1:0] dout,
  output logic [NUM_READ-1:0]                read_busy,
  input  logic                               issue_valid,
  input  logic [ADDR_W-1:0]                  issue_rd,
  output logic                               issue_ready,
  input  logic                               wb_enable,
  input  logic [ADDR_W-1:0]                  wb_rd,
  input  logic [REG_DATA_WIDTH-1:0]          wb_data,
  output logic [NUM_REGS-1:0]                busy_vec
);

  logic [REG_DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [REG_DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [ADDR_W-1:0]         rd_addr [NUM_READ];
  logic                      wb_writable;

  // Addresses backed by real storage; register 0 reads as zero when hardwired.
  function automatic logic readable(input logic [ADDR_W-1:0] a);
    return reg_in_range(32'(a), NUM_REGS) && !((ZERO_REG != 0) && (a == ADDR_W'(REG_ZERO)));
  endfunction

  assign wb_writable = wb_enable && readable(wb_rd);

  // Split the flattened read address bus into per-port addresses.
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rd_addr[i] = read_addr[port_lsb(i, ADDR_W) +: ADDR_W];
    end
  end

  // Next storage contents: at most one register changes per cycle.
  always_comb begin
    regs_d = regs_q;
    if (wb_writable) begin
      regs_d[wb_rd] = wb_data;
    end
  end

  // Register storage.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxing with optional forwarding of the writeback being presented this cycle.
  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      if (readable(rd_addr[i])) begin
        dout[port_lsb(i, REG_DATA_WIDTH) +: REG_DATA_WIDTH] = regs_q[rd_addr[i]];
      end
      if ((BYPASS != 0) && wb_writable && !RESET && (wb_rd == rd_addr[i])) begin
        dout[port_lsb(i, REG_DATA_WIDTH) +: REG_DATA_WIDTH] = wb_data;
      end
    end
  end

  gpregs_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_READ (NUM_READ),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk         (CLK),
    .rst         (RESET),
    .read_addr   (read_addr),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wb_enable   (wb_enable),
    .wb_rd       (wb_rd),
    .issue_ready (issue_ready),
    .read_busy   (read_busy),
    .busy_vec    (busy_vec)
  );

endmodule

// File: tb/tb_gpregs_sb.sv
// Directed bench: a default 32x32 two-port instance and a 16x64 four-port instance
// without forwarding and without a hardwired zero register.
module tb_gpregs_sb;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  // Instance A: defaults (32 regs, 2 read ports, ZERO_REG=1, BYPASS=1)
  logic [9:0]  a_read_addr;
  logic [63:0] a_dout;
  logic [1:0]  a_read_busy;
  logic        a_issue_valid;
  logic [4:0]  a_issue_rd;
  logic        a_issue_ready;
  logic        a_wb_enable;
  logic [4:0]  a_wb_rd;
  logic [31:0] a_wb_data;
  logic [31:0] a_busy_vec;

  // Instance B: 16 regs, 4 read ports, 64-bit, ZERO_REG=0, BYPASS=0
  logic [15:0]  b_read_addr;
  logic [255:0] b_dout;
  logic [3:0]   b_read_busy;
  logic         b_issue_valid;
  logic [3:0]   b_issue_rd;
  logic         b_issue_ready;
  logic         b_wb_enable;
  logic [3:0]   b_wb_rd;
  logic [63:0]  b_wb_data;
  logic [15:0]  b_busy_vec;

  int n_chk  = 0;
  int n_pass = 0;

  gpregs_sb u_dut_a (
    .CLK         (CLK),
    .RESET       (RESET),
    .read_addr   (a_read_addr),
    .dout        (a_dout),
    .read_busy   (a_read_busy),
    .issue_valid (a_issue_valid),
    .issue_rd    (a_issue_rd),
    .issue_ready (a_issue_ready),
    .wb_enable   (a_wb_enable),
    .wb_rd       (a_wb_rd),
    .wb_data     (a_wb_data),
    .busy_vec    (a_busy_vec)
  );

  gpregs_sb #(
    .REG_DATA_WIDTH (64),
    .NUM_REGS       (gpregs_pkg::RV32E_NUM_REGS),
    .NUM_READ       (4),
    .ZERO_REG       (0),
    .BYPASS         (0)
  ) u_dut_b (
    .CLK         (CLK),
    .RESET       (RESET),
    .read_addr   (b_read_addr),
    .dout        (b_dout),
    .read_busy   (b_read_busy),
    .issue_valid (b_issue_valid),
    .issue_rd    (b_issue_rd),
    .issue_ready (b_issue_ready),
    .wb_enable   (b_wb_enable),
    .wb_rd       (b_wb_rd),
    .wb_data     (b_wb_data),
    .busy_vec    (b_busy_vec)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled off the edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RESET         = 1'b1;
    a_read_addr   = '0;
    a_issue_valid = 1'b0;
    a_issue_rd    = '0;
    a_wb_enable   = 1'b0;
    a_wb_rd       = '0;
    a_wb_data     = '0;
    b_read_addr   = '0;
    b_issue_valid = 1'b0;
    b_issue_rd    = '0;
    b_wb_enable   = 1'b0;
    b_wb_rd       = '0;
    b_wb_data     = '0;

    #12;
    RESET      = 1'b0;
    a_issue_rd = 5'd5;
    #1;
    check("rst_busy_vec", a_busy_vec, 64'h0);
    check("rst_issue_ready", a_issue_ready, 64'h1);
    check("rst_dout", a_dout, 64'h0);

    // 1: reset in the middle of traffic
    a_issue_valid = 1'b1;
    a_issue_rd    = 5'd5;
    tick();
    a_issue_valid = 1'b0;
    check("t1_busy5", a_busy_vec, 64'h20);
    a_wb_enable = 1'b1;
    a_wb_rd     = 5'd5;
    a_wb_data   = 32'hDEADBEEF;
    a_read_addr = {5'd5, 5'd5};
    #1;
    check("t1_bypass", a_dout, 64'hDEADBEEF_DEADBEEF);
    check("t1_rbusy_bypass", a_read_busy, 64'h0);
    RESET = 1'b1;
    #1;
    check("t1_rst_dout", a_dout, 64'h0);
    check("t1_rst_busy_vec", a_busy_vec, 64'h0);
    check("t1_rst_ready", a_issue_ready, 64'h1);
    tick();
    a_wb_enable = 1'b0;
    RESET       = 1'b0;
    #1;
    check("t1_wb_discarded", a_dout, 64'h0);
    check("t1_busy_after", a_busy_vec, 64'h0);

    // 2: write then read on both ports, plus same-cycle forwarding
    a_wb_enable = 1'b1;
    a_wb_rd     = 5'd7;
    a_wb_data   = 32'h12345678;
    a_read_addr = {5'd7, 5'd7};
    #1;
    check("t2_bypass", a_dout, 64'h12345678_12345678);
    tick();
    a_wb_enable = 1'b0;
    #1;
    check("t2_stored", a_dout, 64'h12345678_12345678);
    a_read_addr = {5'd5, 5'd7};
    #1;
    check("t2_ports_indep", a_dout, 64'h00000000_12345678);

    // 3: register 0 is hardwired
    a_wb_enable   = 1'b1;
    a_wb_rd       = 5'd0;
    a_wb_data     = 32'hFFFFFFFF;
    a_issue_valid = 1'b1;
    a_issue_rd    = 5'd0;
    a_read_addr   = {5'd0, 5'd0};
    #1;
    check("t3_dout_bypass0", a_dout, 64'h0);
    check("t3_ready0", a_issue_ready, 64'h1);
    check("t3_rbusy0", a_read_busy, 64'h0);
    tick();
    a_wb_enable   = 1'b0;
    a_issue_valid = 1'b0;
    #1;
    check("t3_busy_vec", a_busy_vec, 64'h0);
    check("t3_dout0", a_dout, 64'h0);

    // 4: reissue of a busy register is refused until writeback
    a_issue_valid = 1'b1;
    a_issue_rd    = 5'd3;
    #1;
    check("t4_ready_first", a_issue_ready, 64'h1);
    tick();
    a_read_addr = {5'd7, 5'd3};
    #1;
    check("t4_ready_second", a_issue_ready, 64'h0);
    check("t4_busy3", a_busy_vec, 64'h8);
    check("t4_rbusy", a_read_busy, 64'h1);
    tick();
    a_issue_valid = 1'b0;
    #1;
    check("t4_busy_unchanged", a_busy_vec, 64'h8);
    a_wb_enable = 1'b1;
    a_wb_rd     = 5'd3;
    a_wb_data   = 32'hA5;
    #1;
    check("t4_rbusy_bypass", a_read_busy, 64'h0);
    check("t4_dout_bypass", a_dout, 64'h12345678_000000A5);
    tick();
    a_wb_enable = 1'b0;
    #1;
    check("t4_busy_cleared", a_busy_vec, 64'h0);
    check("t4_ready_after", a_issue_ready, 64'h1);
    check("t4_rbusy_after", a_read_busy, 64'h0);
    check("t4_dout_after", a_dout, 64'h12345678_000000A5);

    // 5: issue and writeback to the same busy register in one cycle
    a_issue_valid = 1'b1;
    a_issue_rd    = 5'd9;
    tick();
    a_issue_valid = 1'b0;
    #1;
    check("t5_busy9", a_busy_vec, 64'h200);
    a_issue_valid = 1'b1;
    a_issue_rd    = 5'd9;
    a_wb_enable   = 1'b1;
    a_wb_rd       = 5'd9;
    a_wb_data     = 32'h55;
    a_read_addr   = {5'd9, 5'd9};
    #1;
    check("t5_refused", a_issue_ready, 64'h0);
    tick();
    a_wb_enable = 1'b0;
    #1;
    check("t5_busy_cleared", a_busy_vec, 64'h0);
    check("t5_data", a_dout, 64'h00000055_00000055);
    check("t5_retry_ready", a_issue_ready, 64'h1);
    tick();
    a_issue_valid = 1'b0;
    #1;
    check("t5_retry_busy", a_busy_vec, 64'h200);
    check("t5_retry_rbusy", a_read_busy, 64'h3);

    // Issue and writeback to the same idle register: data lands, issue wins
    a_issue_valid = 1'b1;
    a_issue_rd    = 5'd11;
    a_wb_enable   = 1'b1;
    a_wb_rd       = 5'd11;
    a_wb_data     = 32'h77;
    a_read_addr   = {5'd9, 5'd11};
    #1;
    check("t5b_ready", a_issue_ready, 64'h1);
    tick();
    a_issue_valid = 1'b0;
    a_wb_enable   = 1'b0;
    #1;
    check("t5b_busy", a_busy_vec, 64'hA00);
    check("t5b_dout", a_dout, 64'h00000055_00000077);

    // 6: four-port, 16-register, 64-bit instance without forwarding
    b_wb_enable = 1'b1;
    b_wb_rd     = 4'd1;
    b_wb_data   = 64'h11;
    b_read_addr = {4'd1, 4'd15, 4'd2, 4'd1};
    #1;
    check("t6_no_bypass", b_dout[0 +: 64], 64'h0);
    tick();
    b_wb_rd   = 4'd2;
    b_wb_data = 64'h22;
    tick();
    b_wb_rd   = 4'd15;
    b_wb_data = 64'hFF;
    tick();
    b_wb_enable = 1'b0;
    #1;
    check("t6_port0", b_dout[0 +: 64], 64'h11);
    check("t6_port1", b_dout[64 +: 64], 64'h22);
    check("t6_port2", b_dout[128 +: 64], 64'hFF);
    check("t6_port3", b_dout[192 +: 64], 64'h11);

    // Register 0 is an ordinary register when not hardwired
    b_issue_valid = 1'b1;
    b_issue_rd    = 4'd0;
    #1;
    check("t7_ready0", b_issue_ready, 64'h1);
    tick();
    b_read_addr = 16'h0000;
    #1;
    check("t7_busy0", b_busy_vec, 64'h1);
    check("t7_ready0_busy", b_issue_ready, 64'h0);
    b_issue_valid = 1'b0;
    b_wb_enable   = 1'b1;
    b_wb_rd       = 4'd0;
    b_wb_data     = 64'h0123456789ABCDEF;
    #1;
    check("t7_rbusy_no_bypass", b_read_busy, 64'hF);
    check("t7_dout_old", b_dout[0 +: 64], 64'h0);
    tick();
    b_wb_enable = 1'b0;
    #1;
    check("t7_busy_cleared", b_busy_vec, 64'h0);
    check("t7_dout_new", b_dout[192 +: 64], 64'h0123456789ABCDEF);
    check("t7_rbusy_after", b_read_busy, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
